// File: rtl/key_event_pkg.sv
// Shared types and register-map constants for the keyboard event controller.
package key_event_pkg;

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [1:0] ADDR_KEYCODE = 2'd0;
  localparam logic [1:0] ADDR_EVENT   = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int EV_VALID_BIT    = 31;
  localparam int EV_PRESS_BIT    = 8;
  localparam int ST_OVF_BIT      = 8;
  localparam int ST_BUSY_BIT     = 9;
  localparam int ST_IRQEN_BIT    = 10;
  localparam int CTL_FLUSH_BIT   = 0;
  localparam int CTL_CLR_OVF_BIT = 1;
  localparam int CTL_IRQEN_BIT   = 2;

  typedef struct packed {
    logic       press;
    logic [7:0] code;
  } key_event_t;

  // True when byte b matches any of the four bytes of w.
  function automatic logic byte_in(input logic [7:0] b, input logic [31:0] w);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 4; k++)
      if (w[8*k +: 8] == b) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Event FIFO: power-of-two depth, flush dominates push/pop, push into a full FIFO only lands with a same-cycle pop.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  key_event_t    wdata,
  output key_event_t    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  key_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Avalon-MM keyboard event controller: diffs successive keycode words into press/release events.
// Optional KEY_EVENT_IRQ_EN adds the irq port and CONTROL bit2 interrupt enable.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [31:0] out_port
`ifdef KEY_EVENT_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic [2:0]    idx;
  logic [31:0]   cur, prev;
  logic          overflow;
  logic          irq_en;

  logic          wr_sel, rd_sel, kc_wr, kc_accept, ctl_wr;
  logic          flush, clr_ovf, ev_pop, ev_push, qualify;
  logic [7:0]    cur_byte, prev_byte;
  key_event_t    ev, fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign wr_sel      = chipselect & ~write_n;
  assign rd_sel      = chipselect & ~read_n;
  assign kc_wr       = wr_sel & (address == ADDR_KEYCODE);
  assign kc_accept   = kc_wr & (state == IDLE);
  assign waitrequest = kc_wr & (state == SCAN);
  assign ctl_wr      = wr_sel & (address == ADDR_CONTROL);
  assign flush       = ctl_wr & writedata[CTL_FLUSH_BIT];
  assign clr_ovf     = ctl_wr & writedata[CTL_CLR_OVF_BIT];
  assign ev_pop      = rd_sel & (address == ADDR_EVENT);
  assign out_port    = cur;

  // Index 0..3 checks cur bytes for presses, 4..7 checks prev bytes for releases.
  assign cur_byte  = cur[{idx[1:0], 3'b000} +: 8];
  assign prev_byte = prev[{idx[1:0], 3'b000} +: 8];

  always_comb begin
    ev      = '0;
    qualify = 1'b0;
    if (!idx[2]) begin
      ev      = '{press: 1'b1, code: cur_byte};
      qualify = (cur_byte != 8'h00) && !byte_in(cur_byte, prev);
    end else begin
      ev      = '{press: 1'b0, code: prev_byte};
      qualify = (prev_byte != 8'h00) && !byte_in(prev_byte, cur);
    end
  end

  assign ev_push = (state == SCAN) & qualify;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cur   <= '0;
      prev  <= '0;
    end else begin
      case (state)
        IDLE: if (kc_accept) begin
          cur   <= writedata;
          prev  <= cur;
          idx   <= '0;
          state <= SCAN;
        end
        SCAN: begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A push is lost only when the FIFO is full and nothing leaves it this cycle.
  always_ff @(posedge clk) begin
    if (reset || clr_ovf)
      overflow <= 1'b0;
    else if (ev_push && fifo_full && !ev_pop && !flush)
      overflow <= 1'b1;
  end

`ifdef KEY_EVENT_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctl_wr) irq_en <= writedata[CTL_IRQEN_BIT];
      irq <= irq_en & (fifo_count != '0);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev_push),
    .pop   (ev_pop),
    .flush (flush),
    .wdata (ev),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_KEYCODE: readdata = cur;
      ADDR_EVENT: if (!fifo_empty) begin
        readdata[EV_VALID_BIT] = 1'b1;
        readdata[8:0]          = fifo_rdata;
      end
      ADDR_STATUS: begin
        readdata[5:0]        = 6'(fifo_count);
        readdata[ST_OVF_BIT]   = overflow;
        readdata[ST_BUSY_BIT]  = (state == SCAN);
        readdata[ST_IRQEN_BIT] = irq_en;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl; expected EVENT words queue up at each keycode write and are popped on reads.
module tb_key_event_ctrl;
  import key_event_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] out_port;
`ifdef KEY_EVENT_IRQ_EN
  logic        irq;
`endif

  key_event_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .read_n      (read_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .out_port    (out_port)
`ifdef KEY_EVENT_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] new_ev[$];
  logic [31:0] cur_m = '0;
  logic        ovf_m = 1'b0;
  logic        irqen_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_word(input logic [7:0] b, input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      if (w[8*k +: 8] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Expected EVENT words for a keycode change: presses by byte order, then releases.
  task automatic gen_events(input logic [31:0] o, input logic [31:0] n);
    logic [7:0] b;
    new_ev.delete();
    for (int i = 0; i < 4; i++) begin
      b = n[8*i +: 8];
      if (b != 8'h00 && !in_word(b, o)) new_ev.push_back(32'h8000_0100 | {24'b0, b});
    end
    for (int i = 0; i < 4; i++) begin
      b = o[8*i +: 8];
      if (b != 8'h00 && !in_word(b, n)) new_ev.push_back(32'h8000_0000 | {24'b0, b});
    end
  endtask

  task automatic model_push(input logic [31:0] e);
    if (exp_q.size() == DEPTH) ovf_m = 1'b1;
    else exp_q.push_back(e);
  endtask

  function automatic logic [31:0] status_exp(input logic busy);
    return {21'b0, irqen_m, busy, ovf_m, 2'b0, 6'(exp_q.size())};
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stall);
    stall = 0;
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    #1;
    while (waitrequest && stall < 50) begin
      @(negedge clk);
      #1;
      stall++;
    end
    check("write_accepted", {31'b0, waitrequest}, 32'h0);
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1;
    d = readdata;
    @(posedge clk);
    #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic keycode(input logic [31:0] v, output int stall);
    gen_events(cur_m, v);
    foreach (new_ev[i]) model_push(new_ev[i]);
    cur_m = v;
    bus_write(ADDR_KEYCODE, v, stall);
  endtask

  task automatic drain(input string tag);
    logic [31:0] d;
    while (exp_q.size() > 0) begin
      bus_read(ADDR_EVENT, d);
      check(tag, d, exp_q.pop_front());
    end
    bus_read(ADDR_EVENT, d);
    check({tag, "_empty"}, d, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int s, s2;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_port", out_port, 32'h0);
    check("rst_waitrequest", {31'b0, waitrequest}, 32'h0);
`ifdef KEY_EVENT_IRQ_EN
    check("rst_irq", {31'b0, irq}, 32'h0);
`endif
    bus_read(ADDR_KEYCODE, d); check("rst_keycode", d, 32'h0);
    bus_read(ADDR_STATUS, d);  check("rst_status", d, 32'h0);
    bus_read(ADDR_EVENT, d);   check("rst_event", d, 32'h0);
    bus_read(ADDR_CONTROL, d); check("control_reads_zero", d, 32'h0);

    // Single press, then empty read
    keycode(32'h0000_001A, s);
    repeat (9) @(posedge clk);
    check("out_port_1a", out_port, 32'h0000_001A);
    bus_read(ADDR_KEYCODE, d); check("keycode_1a", d, 32'h0000_001A);
    bus_read(ADDR_EVENT, d);   check("event_press_1a", d, 32'h8000_011A);
    void'(exp_q.pop_front());
    bus_read(ADDR_EVENT, d);   check("event_empty_1a", d, 32'h0);

    // Partial overlap: only changed bytes generate events
    keycode(32'h0000_1A2C, s);
    repeat (9) @(posedge clk);
    drain("ev_1a2c");
    keycode(32'h0000_2C16, s);
    repeat (9) @(posedge clk);
    drain("ev_2c16");

    // Back-to-back writes stall for the whole scan; busy visible throughout
    keycode(32'h0000_0033, s);
    keycode(32'h0000_0044, s2);
    check("stall_cycles", 32'(s2), 32'd8);
    for (int i = 0; i < 9; i++) begin
      bus_read(ADDR_STATUS, d);
      check("status_busy", {31'b0, d[ST_BUSY_BIT]}, (i < 8) ? 32'h1 : 32'h0);
    end
    drain("ev_b2b");

    // Overflow and clear
    keycode(32'h0, s);
    repeat (9) @(posedge clk);
    drain("ev_clear");
    keycode(32'h1111_1111, s);
    keycode(32'h2222_2222, s);
    repeat (9) @(posedge clk);
    bus_read(ADDR_STATUS, d); check("status_overflow", d, status_exp(1'b0));
    check("status_overflow_const", d, 32'h0000_0108);
    bus_write(ADDR_CONTROL, 32'h2, s);
    ovf_m = 1'b0;
    bus_read(ADDR_STATUS, d); check("status_ovf_cleared", d, 32'h0000_0008);

    // Pops coincide with every scan push while full
    gen_events(cur_m, 32'h3333_3333);
    cur_m = 32'h3333_3333;
    bus_write(ADDR_KEYCODE, 32'h3333_3333, s);
    for (int i = 0; i < 8; i++) begin
      bus_read(ADDR_EVENT, d);
      check("full_push_pop", d, exp_q.pop_front());
      model_push(new_ev[i]);
    end
    bus_read(ADDR_STATUS, d); check("full_push_pop_status", d, status_exp(1'b0));
    check("full_push_pop_const", d, 32'h0000_0008);
    drain("ev_full_pp");

    // Flush discards queued events
    keycode(32'h0000_0077, s);
    repeat (9) @(posedge clk);
    bus_write(ADDR_CONTROL, 32'h1, s);
    exp_q.delete();
    bus_read(ADDR_STATUS, d); check("flush_status", d, 32'h0);
    bus_read(ADDR_EVENT, d);  check("flush_event", d, 32'h0);

    // Interrupt enable (reads back only in the irq build)
    bus_write(ADDR_CONTROL, 32'h4, s);
`ifdef KEY_EVENT_IRQ_EN
    irqen_m = 1'b1;
`endif
    bus_read(ADDR_STATUS, d); check("irqen_status", d, status_exp(1'b0));
`ifdef KEY_EVENT_IRQ_EN
    keycode(32'h0000_0099, s);
    check("irq_before_push", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_at_push", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_after_push", {31'b0, irq}, 32'h1);
    repeat (9) @(posedge clk);
    drain("ev_irq");
`endif

    // Reset mid-scan abandons pending events
    keycode(32'hAB00_00CD, s);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midscan_out_port", out_port, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    cur_m = '0; ovf_m = 1'b0; irqen_m = 1'b0;
    bus_read(ADDR_STATUS, d);  check("midscan_status", d, 32'h0);
    bus_read(ADDR_KEYCODE, d); check("midscan_keycode", d, 32'h0);
    repeat (10) @(posedge clk);
    bus_read(ADDR_STATUS, d);  check("midscan_status_late", d, status_exp(1'b0));
    bus_read(ADDR_EVENT, d);   check("midscan_event", d, 32'h0);
`ifdef KEY_EVENT_IRQ_EN
    check("midscan_irq", {31'b0, irq}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries; power of two, 2..32.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port address, input, 2: Avalon-MM word address.
REQ-005 SHALL have port chipselect, input, 1: slave select.
REQ-006 SHALL have port write_n, input, 1: active-low write strobe.
REQ-007 SHALL have port read_n, input, 1: active-low read strobe.
REQ-008 SHALL have port writedata, input, 32: write data.
REQ-009 SHALL have port readdata, output, 32: combinational read data, zero read latency.
REQ-010 SHALL have port waitrequest, output, 1: stalls KEYCODE writes while a scan is running.
REQ-011 SHALL have port out_port, output, 32: current packed keycodes, four bytes, to game logic.
REQ-012 SHALL have port irq, output, 1: event interrupt; present only with KEY_EVENT_IRQ_EN.

Function
REQ-013 SHALL decode the register map: 0 = KEYCODE (RW); 1 = EVENT (RO, pop on read); 2 = STATUS (RO); 3 = CONTROL (WO, reads 0).
REQ-014 SHALL accept a KEYCODE write only in IDLE: cur <= writedata, prev <= old cur, state <= SCAN, index <= 0; waitrequest low in the accept cycle.
REQ-015 SHALL hold waitrequest high for a KEYCODE write in SCAN until IDLE, then accept the write; other addresses never stall.
REQ-016 SHALL run SCAN for exactly 8 cycles, index 0..7, then return to IDLE, so the next KEYCODE write is accepted 9 cycles after the previous one.
REQ-017 SHALL, for index i in 0..3, push press event {1, cur byte i} if that byte is nonzero and equals no prev byte.
REQ-018 SHALL, for index i in 4..7, push release event {0, prev byte i-4} if that byte is nonzero and equals no cur byte.
REQ-019 SHALL push one event per qualifying byte, duplicates included; byte 0x00 means empty slot and never generates an event.
REQ-020 SHALL format EVENT readdata as: bit31 valid (FIFO non-empty), bit8 press=1/release=0, bits7:0 code, other bits 0.
REQ-021 SHALL pop on chipselect & ~read_n & address==1; reading an empty FIFO returns 0 and changes nothing.
REQ-022 SHALL, on push to a full FIFO, drop the event and set sticky overflow.
REQ-023 SHALL perform a simultaneous push and pop both, leaving count unchanged, including when full.
REQ-024 SHALL format STATUS as: bits5:0 count, bit8 overflow, bit9 busy (state==SCAN).
REQ-025 SHALL implement CONTROL bit0 = flush FIFO and bit1 = clear overflow, both self-clearing and taking priority over a same-cycle push/pop; an in-progress scan continues and pushes on later cycles.
REQ-026 SHALL drive out_port = cur, updated the cycle after the accepted write.
REQ-027 SHALL return cur on KEYCODE reads.

Reset
REQ-028 SHALL, on reset, clear cur, prev, FIFO, count, overflow, index and irq enable, set state IDLE, and drive waitrequest, out_port and irq to 0.
REQ-029 SHALL, on reset during SCAN, abandon the scan; pending events are lost.

Configuration
REQ-030 SHALL, when KEY_EVENT_IRQ_EN is defined, add CONTROL bit2 = irq enable (readable as STATUS bit10), with irq = enable & (count != 0), registered.
REQ-031 SHALL, when KEY_EVENT_IRQ_EN is undefined, omit the irq port, ignore CONTROL bit2, and read STATUS bit10 as 0.

Structure
REQ-032 SHALL place in package key_event_pkg: the state enum (IDLE, SCAN), register address constants, event/STATUS bit positions and the event typedef (9-bit).
REQ-033 SHALL implement the event FIFO as sub-module key_event_fifo (push, pop, flush, full, empty, count); the scan FSM and bus decode stay in key_event_ctrl.

Verification
REQ-034 SHALL cover: write 0x0000001A, wait 9 cycles, read EVENT -> 0x8000011A; read again -> 0.
REQ-035 SHALL cover: cur 0x00001A2C, write 0x00002C16 -> events press 0x16 then release 0x1A; 0x2C produces no event.
REQ-036 SHALL cover: back-to-back KEYCODE writes -> second write sees waitrequest high for 8 cycles; STATUS busy=1 during that time.
REQ-037 SHALL cover: FIFO_DEPTH=8, 9 press events without reads -> count 8, overflow 1; CONTROL 0x2 -> overflow 0, count 8.
REQ-038 SHALL cover: pop on the same cycle as a push with FIFO full -> count stays 8, no overflow.
REQ-039 SHALL cover: reset asserted mid-scan -> state IDLE, count 0, out_port 0 next cycle; with KEY_EVENT_IRQ_EN, irq rises one cycle after the first push when enabled.
